regfile_wb_scheduler: RTL
=========================

// Module: regfile_wb_scheduler
// PURPOSE
//  Write-port controller and scoreboard for the 32x32 register file (negedge write, async read, x0 = 0).
//  Round-robin arbitrates NUM_REQ writeback sources (ALU, load, mul/div) onto the single write port.
//  Tracks in-flight destination registers and stalls decode on RAW/WAW hazards.
//  Sits between the writeback units / decode stage and the register file.
// PARAMETERS
//  NUM_REQ  3   number of writeback requesters (>=2)
//  XLEN     32  data width
// PORTS
//  clk              in   1              rising-edge clock
//  rst              in   1              asynchronous reset, active high
//  issue_valid      in   1              decode issuing an instr that writes issue_rd
//  issue_rd         in   5              destination of issuing instr
//  issue_rs1        in   5              source 1 of issuing instr
//  issue_rs2        in   5              source 2 of issuing instr
//  issue_stall      out  1              hazard: hold decode this cycle
//  wb_valid         in   NUM_REQ        requester i has a result
//  wb_rd            in   NUM_REQ*5      dest of requester i, slice [5i+4:5i]
//  wb_data          in   NUM_REQ*XLEN   data of requester i
//  wb_ready         out  NUM_REQ        one-hot grant; transfer = valid & ready
//  reg_write        out  1              regfile write enable
//  rd_addr          out  5              regfile write address
//  regf_write_data  out  XLEN           regfile write data
//  busy_mask        out  32             scoreboard; bit r = write to xr pending
//  wb_orphan        out  1              1-cycle pulse: writeback to non-busy reg
// BEHAVIOUR
//  Reset (async): busy=0, reg_write=0, rd_addr=0, regf_write_data=0, wb_orphan=0, rr_ptr=0.
//   wb_ready=0 while rst high; in-flight requests discarded; restarts in scan order from 0.
//  Arbitration (combinational): grant = first i with wb_valid[i], scanning rr_ptr..NUM_REQ-1 then 0..rr_ptr-1.
//   At most one wb_ready bit high; none if no wb_valid. ready depends on valid; requesters
//   must hold valid/rd/data stable until transfer and never gate valid on ready.
//   On transfer rr_ptr <= (grant+1) mod NUM_REQ; otherwise rr_ptr holds.
//  Write port (registered, latency 1): on transfer edge reg_write <= (wb_rd!=0),
//   rd_addr <= wb_rd, regf_write_data <= wb_data; no transfer -> reg_write <= 0, addr/data hold.
//   Regfile captures on the falling edge of the cycle reg_write is high.
//   Transfer to x0: accepted (ready given), reg_write stays 0, no orphan flag.
//  Scoreboard: busy[0] hard 0. Set busy[issue_rd] on issue_valid & !issue_stall & issue_rd!=0.
//   Clear busy[wb_rd] on transfer (same edge reg_write rises).
//   Same-edge set and clear of different regs both take effect; same reg impossible (issue stalls).
//  Orphan: transfer with wb_rd!=0 and busy[wb_rd]==0 -> write still performed,
//   wb_orphan <= 1 for one cycle.
//  Stall (combinational): issue_stall = issue_valid & (busy[rs1] | busy[rs2] | busy[rd]).
//   Uses registered busy only, no same-cycle bypass. Stall drops in the cycle reg_write is high;
//   async regfile read is valid after that cycle's falling edge.
//   issue_valid=0 -> issue_stall=0.
//  busy_mask is the registered scoreboard, bit 0 always 0.
// TESTING
//  1 Reset: rst high mid-transfer with busy[3,9] set -> all outputs 0, busy_mask=0, wb_ready=0.
//  2 Issue rd=5; next cycle issue rs1=5 -> issue_stall=1. wb_valid[0], rd=5, data=0xDEADBEEF
//    -> next cycle reg_write=1, rd_addr=5, data=0xDEADBEEF, busy_mask[5]=0, stall=0.
//  3 All three wb_valid held high -> wb_ready sequence 001,010,100,001; one reg_write per cycle.
//  4 wb_rd=0 transfer -> wb_ready=1, reg_write=0, wb_orphan=0. Issue rd=0 -> no stall, busy_mask=0.
//  5 Writeback rd=7 with busy[7]=0 -> reg_write=1, rd_addr=7, wb_orphan=1 for exactly one cycle.
//  6 rr_ptr=2, only wb_valid[1] -> wb_ready=010 same cycle (wrap); afterwards rr_ptr=2.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port arbiter and in-flight destination scoreboard.
// Round-robin grants one writeback per cycle and stalls decode on RAW/WAW hazards.
module regfile_wb_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  input  logic [4:0]              issue_rs1,
  input  logic [4:0]              issue_rs2,
  output logic                    issue_stall,
  input  logic [NUM_REQ-1:0]      wb_valid,
  input  logic [NUM_REQ*5-1:0]    wb_rd,
  input  logic [NUM_REQ*XLEN-1:0] wb_data,
  output logic [NUM_REQ-1:0]      wb_ready,
  output logic                    reg_write,
  output logic [4:0]              rd_addr,
  output logic [XLEN-1:0]         regf_write_data,
  output logic [31:0]             busy_mask,
  output logic                    wb_orphan
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [31:0]        busy_q, busy_d;
  logic               reg_write_q, reg_write_d;
  logic [4:0]         rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic               orphan_q, orphan_d;

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] hi_req;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      gnt_idx;
  logic               found;
  logic               transfer;
  logic [4:0]         sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic               issue_fire;

  // Requests at or above the pointer win first; otherwise wrap to the low end.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (PW'(i) >= rr_ptr_q);
    end
    hi_req   = wb_valid & hi_mask;
    pick_req = (|hi_req) ? hi_req : wb_valid;
    gnt_idx  = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && pick_req[i]) begin
        gnt_idx = PW'(i);
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    grant    = '0;
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (found && (gnt_idx == PW'(i))) begin
        grant[i] = 1'b1;
        sel_rd   = wb_rd[i*5 +: 5];
        sel_data = wb_data[i*XLEN +: XLEN];
      end
    end
  end

  assign wb_ready = rst ? '0 : grant;
  assign transfer = found & ~rst;

  assign issue_stall = issue_valid &
                       (busy_q[issue_rs1] |
                        busy_q[issue_rs2] |
                        busy_q[issue_rd]);

  assign issue_fire = issue_valid & ~issue_stall &
                      (issue_rd != 5'd0);

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    reg_write_d = 1'b0;
    rd_addr_d   = rd_addr_q;
    wdata_d     = wdata_q;
    orphan_d    = 1'b0;
    busy_d      = busy_q;
    if (transfer) begin
      if (gnt_idx == PW'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx + PW'(1);
      end
      reg_write_d     = (sel_rd != 5'd0);
      rd_addr_d       = sel_rd;
      wdata_d         = sel_data;
      orphan_d        = (sel_rd != 5'd0) & ~busy_q[sel_rd];
      busy_d[sel_rd]  = 1'b0;
    end
    // Issue to the register being retired this edge cannot happen: it stalls.
    if (issue_fire) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      busy_q      <= '0;
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
      wdata_q     <= '0;
      orphan_q    <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
      wdata_q     <= wdata_d;
      orphan_q    <= orphan_d;
    end
  end

  assign reg_write       = reg_write_q;
  assign rd_addr         = rd_addr_q;
  assign regf_write_data = wdata_q;
  assign busy_mask       = busy_q;
  assign wb_orphan       = orphan_q;

endmodule
